// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared definitions for the push-button conditioning block:
//                auto-repeat FSM state encoding, default timing constants for
//                a 50 MHz system clock, and small sizing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Auto-repeat state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Default timing at 50 MHz
    localparam int c_DEBOUNCE_CYCLES_50M = 1_000_000;  // 20 ms
    localparam int c_REPEAT_DELAY_50M    = 25_000_000; // 500 ms
    localparam int c_REPEAT_PERIOD_50M   = 5_000_000;  // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0 .. n-1; never narrower than one bit so a
    // degenerate count of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both stages reset to RESET_VAL.
//  Ports       : clk     - destination clock
//                rst_n   - asynchronous active-low reset
//                data_i  - asynchronous input
//                data_o  - synchronised output (two clk cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_i,
    output logic data_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Conditions one raw push-button pin into a debounced level,
//                single-cycle press/release strobes, an optional auto-repeat
//                strobe while held, and a combined click strobe.
//  Ports       : clk           - system clock
//                rst_n         - asynchronous active-low reset
//                button_async  - raw pin, asynchronous to clk
//                button_level  - debounced level, 1 = pressed
//                press_pulse   - one-cycle strobe on accepted press
//                release_pulse - one-cycle strobe on accepted release
//                repeat_pulse  - one-cycle strobe per auto-repeat tick
//                click         - press_pulse | repeat_pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_50M,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD_50M,
    parameter bit REPEAT_EN       = 1'b1,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_async,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic click
);

    localparam int c_DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int c_RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE      = c_DB_W'(1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_ONE     = c_RPT_W'(1);

    // ------------------------------------------------------------------
    // Polarity normalisation and synchronisation. Inverting ahead of the
    // synchroniser lets its reset value of 0 mean "released".
    // ------------------------------------------------------------------
    logic w_pin_active;
    logic w_sample;

    assign w_pin_active = ACTIVE_LOW ? ~button_async : button_async;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (w_pin_active),
        .data_o (w_sample)
    );

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles the sample disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    logic              level_q,  level_d;
    logic [c_DB_W-1:0] db_cnt_q, db_cnt_d;
    logic              w_accept;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        w_accept = 1'b0;
        if (w_sample != level_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                w_accept = 1'b1;
                level_d  = w_sample;
            end else begin
                db_cnt_d = db_cnt_q + c_DB_ONE;
            end
        end
    end

    logic press_d;
    logic release_d;
    logic repeat_d;
    logic click_d;

    assign press_d   = w_accept &  w_sample;
    assign release_d = w_accept & ~w_sample;

    // ------------------------------------------------------------------
    // Auto-repeat state machine
    // ------------------------------------------------------------------
    generate
        if (REPEAT_EN) begin : g_repeat
            rpt_state_e         state_q,   state_d;
            logic [c_RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q   <= ST_IDLE;
                    rpt_cnt_q <= '0;
                end else begin
                    state_q   <= state_d;
                    rpt_cnt_q <= rpt_cnt_d;
                end
            end

            // A release accepted on the same edge as a terminal count wins:
            // the button is no longer held, so no repeat strobe is issued.
            always_comb begin
                state_d   = state_q;
                rpt_cnt_d = rpt_cnt_q;
                repeat_d  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        rpt_cnt_d = '0;
                        if (press_d) begin
                            state_d = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (release_d) begin
                            state_d   = ST_IDLE;
                            rpt_cnt_d = '0;
                        end else if (rpt_cnt_q == c_DELAY_LAST) begin
                            repeat_d  = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = ST_REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + c_RPT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (release_d) begin
                            state_d   = ST_IDLE;
                            rpt_cnt_d = '0;
                        end else if (rpt_cnt_q == c_PERIOD_LAST) begin
                            repeat_d  = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + c_RPT_ONE;
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        rpt_cnt_d = '0;
                    end
                endcase
            end
        end else begin : g_no_repeat
            assign repeat_d = 1'b0;
        end
    endgenerate

    assign click_d = press_d | repeat_d;

    // ------------------------------------------------------------------
    // Output and debounce registers
    // ------------------------------------------------------------------
    logic press_q;
    logic release_q;
    logic repeat_q;
    logic click_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            click_q   <= click_d;
        end
    end

    assign button_level  = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign click         = click_q;

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer. Two instances share
//                the pin: one with auto-repeat, one without. A cycle-level
//                behavioural model (run-length debounce, time-since-press
//                repeat rule) is compared against every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pin   = 1'b1;

    logic lvl_a, prs_a, rel_a, rep_a, clk_a;
    logic lvl_b, prs_b, rel_b, rep_b, clk_b;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (1'b1),
        .ACTIVE_LOW      (1'b1)
    ) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_async  (pin),
        .button_level  (lvl_a),
        .press_pulse   (prs_a),
        .release_pulse (rel_a),
        .repeat_pulse  (rep_a),
        .click         (clk_a)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (1'b0),
        .ACTIVE_LOW      (1'b1)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_async  (pin),
        .button_level  (lvl_b),
        .press_pulse   (prs_b),
        .release_pulse (rel_b),
        .repeat_pulse  (rep_b),
        .click         (clk_b)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Reference model: pressed-ness passes through a two-cycle delay line;
    // the level flips once the delayed sample has disagreed with it for DC
    // consecutive cycles. Repeats fire when the cycles elapsed since the
    // press reach RD, RD+RP, RD+2RP, ... while still held.
    // ------------------------------------------------------------------
    typedef struct {
        bit s1;
        bit s2;
        bit level;
        int run;
        int t;
        bit press;
        bit rel;
        bit rep;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mstep(input mdl_t m, input bit pin_v, input bit en);
        mdl_t n;
        bit   smp;
        n       = m;
        smp     = m.s2;
        n.s2    = m.s1;
        n.s1    = ~pin_v;
        n.press = 1'b0;
        n.rel   = 1'b0;
        n.rep   = 1'b0;
        n.run   = (smp != m.level) ? m.run + 1 : 0;
        if (n.run == DC) begin
            n.level = smp;
            n.run   = 0;
            n.press = smp;
            n.rel   = !smp;
        end
        if (n.press) begin
            n.t = 0;
        end else if (n.level && m.level) begin
            n.t = m.t + 1;
            if (en && n.t >= RD && ((n.t - RD) % RP) == 0)
                n.rep = 1'b1;
        end
        return n;
    endfunction

    int cnt_pa, cnt_ra, cnt_qa, cnt_pb, cnt_rb, cnt_qb;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk_bit({nm, " level_a"}, lvl_a, 1'b0);
        chk_bit({nm, " press_a"}, prs_a, 1'b0);
        chk_bit({nm, " rel_a"},   rel_a, 1'b0);
        chk_bit({nm, " rep_a"},   rep_a, 1'b0);
        chk_bit({nm, " click_a"}, clk_a, 1'b0);
        chk_bit({nm, " level_b"}, lvl_b, 1'b0);
        chk_bit({nm, " press_b"}, prs_b, 1'b0);
        chk_bit({nm, " rel_b"},   rel_b, 1'b0);
        chk_bit({nm, " rep_b"},   rep_b, 1'b0);
        chk_bit({nm, " click_b"}, clk_b, 1'b0);
    endtask

    // One clock: drive pin, advance model on the edge, compare 1 ns later.
    task automatic tick(input bit p);
        pin = p;
        @(posedge clk);
        ma = mstep(ma, p, 1'b1);
        mb = mstep(mb, p, 1'b0);
        #1;
        chk_bit("level_a", lvl_a, ma.level);
        chk_bit("press_a", prs_a, ma.press);
        chk_bit("rel_a",   rel_a, ma.rel);
        chk_bit("rep_a",   rep_a, ma.rep);
        chk_bit("click_a", clk_a, ma.press | ma.rep);
        chk_bit("level_b", lvl_b, mb.level);
        chk_bit("press_b", prs_b, mb.press);
        chk_bit("rel_b",   rel_b, mb.rel);
        chk_bit("rep_b",   rep_b, mb.rep);
        chk_bit("click_b", clk_b, mb.press | mb.rep);
        cnt_pa += int'(prs_a); cnt_ra += int'(rel_a); cnt_qa += int'(rep_a);
        cnt_pb += int'(prs_b); cnt_rb += int'(rel_b); cnt_qb += int'(rep_b);
    endtask

    // Hold the pin and count cycles until the chosen strobe on instance A.
    task automatic run_until(input bit p, input bit want_release, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(p);
            if (want_release ? rel_a : prs_a) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        bit pin;
        int cycles;
        int a_press, a_release, a_repeat;
        int b_press, b_release, b_repeat;
    } seg_t;

    seg_t tbl[9];

    int n;
    int s_pa, s_ra, s_qa, s_pb, s_rb, s_qb;
    int total;
    int len;
    bit p;

    initial begin
        // pin, cycles, A press/release/repeat, B press/release/repeat
        tbl[0] = '{1'b1, 10, 0, 0, 0, 0, 0, 0};  // idle
        tbl[1] = '{1'b0, 30, 1, 0, 5, 1, 0, 0};  // press at 6, repeats at +10..+22
        tbl[2] = '{1'b1, 10, 0, 1, 2, 0, 1, 0};  // repeats at +25,+28 then release
        tbl[3] = '{1'b0,  3, 0, 0, 0, 0, 0, 0};  // glitch one short of acceptance
        tbl[4] = '{1'b1, 10, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{1'b0,  4, 0, 0, 0, 0, 0, 0};  // glitch exactly at acceptance
        tbl[6] = '{1'b1, 12, 1, 1, 0, 1, 1, 0};  // its press and release land here
        tbl[7] = '{1'b0, 40, 1, 0, 9, 1, 0, 0};  // long hold
        tbl[8] = '{1'b1, 10, 0, 1, 1, 0, 1, 0};

        ma = '{default: 0};
        mb = '{default: 0};
        cnt_pa = 0; cnt_ra = 0; cnt_qa = 0; cnt_pb = 0; cnt_rb = 0; cnt_qb = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Table-driven segments
        for (int k = 0; k < 9; k++) begin
            s_pa = cnt_pa; s_ra = cnt_ra; s_qa = cnt_qa;
            s_pb = cnt_pb; s_rb = cnt_rb; s_qb = cnt_qb;
            for (int c = 0; c < tbl[k].cycles; c++) tick(tbl[k].pin);
            chk_int($sformatf("seg%0d a_press", k),   cnt_pa - s_pa, tbl[k].a_press);
            chk_int($sformatf("seg%0d a_release", k), cnt_ra - s_ra, tbl[k].a_release);
            chk_int($sformatf("seg%0d a_repeat", k),  cnt_qa - s_qa, tbl[k].a_repeat);
            chk_int($sformatf("seg%0d b_press", k),   cnt_pb - s_pb, tbl[k].b_press);
            chk_int($sformatf("seg%0d b_release", k), cnt_rb - s_rb, tbl[k].b_release);
            chk_int($sformatf("seg%0d b_repeat", k),  cnt_qb - s_qb, tbl[k].b_repeat);
        end

        // Clean press: level and strobes six cycles after the pin edge
        run_until(1'b0, 1'b0, 20, n);
        chk_int("clean_press_latency", n, 2 + DC);
        chk_bit("clean_press_click", clk_a, 1'b1);
        chk_bit("clean_press_level", lvl_a, 1'b1);

        // Release accepted on the very edge the first repeat would fire
        s_qa = cnt_qa;
        repeat (4) tick(1'b0);
        run_until(1'b1, 1'b1, 20, n);
        chk_int("release_in_delay_latency", n, 2 + DC);
        chk_bit("release_in_delay_no_rep", rep_a, 1'b0);
        chk_int("release_in_delay_rep_cnt", cnt_qa - s_qa, 0);
        repeat (15) tick(1'b1);
        chk_int("idle_after_release_rep_cnt", cnt_qa - s_qa, 0);

        // Bounce: toggling every 2 cycles never qualifies
        s_pa = cnt_pa;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0) ? 1'b0 : 1'b1);
            tick((i % 2 == 0) ? 1'b0 : 1'b1);
        end
        chk_int("bounce_no_press", cnt_pa - s_pa, 0);
        run_until(1'b0, 1'b0, 20, n);
        chk_int("bounce_press_latency", n, 2 + DC);

        // Reset while a repeat strobe is high
        repeat (RD) tick(1'b0);
        chk_bit("rep_before_reset", rep_a, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        ma = '{default: 0};
        mb = '{default: 0};
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_all_zero("in_reset");
        end
        rst_n = 1'b1;
        run_until(1'b0, 1'b0, 20, n);
        chk_int("press_after_reset_latency", n, 2 + DC);
        repeat (5) tick(1'b1);
        repeat (10) tick(1'b1);

        // Random pin activity against the model
        total = 0;
        while (total < 400) begin
            p   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            repeat (len) tick(p);
            total += len;
        end
        repeat (20) tick(1'b1);
        chk_bit("final_level_a", lvl_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_button_debouncer
`default_nettype wire
